mux8_rr_arbiter: RTL

Round-robin arbiter and sequencer for the 8-to-1 16-bit multiplexer. It shares the single 16-bit path among eight requesters. The block grants one requester at a time and drives the mux select. Each grant moves up to MAX_BEATS words to a single consumer over a valid/ready handshake, then rotates priority. It sits between the eight data producers and the one shared 16-bit sink.

---
 rtl/mux8_rr_arbiter_pkg.sv | 24 ++
 rtl/mux8_rr_arbiter_mux.sv | 30 +++
 rtl/mux8_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter around the
// 8-to-1 16-bit multiplexer.
package mux8_rr_arbiter_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Result of a cyclic priority search over the request vector.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// 8-to-1 16-bit multiplexer; op selects one of a..h.
module Mux8x1_16Bit
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        case (op)
            3'd0:    y = a;
            3'd1:    y = b;
            3'd2:    y = c;
            3'd3:    y = d;
            3'd4:    y = e;
            3'd5:    y = f;
            3'd6:    y = g;
            default: y = h;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one 16-bit path among eight
// requesters; each grant moves up to MAX_BEATS words, then priority rotates.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        req,
    input  logic [15:0]       in0,
    input  logic [15:0]       in1,
    input  logic [15:0]       in2,
    input  logic [15:0]       in3,
    input  logic [15:0]       in4,
    input  logic [15:0]       in5,
    input  logic [15:0]       in6,
    input  logic [15:0]       in7,
    output logic [7:0]        grant,
    output logic [2:0]        sel,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned   CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    arb_state_t       state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [SEL_W-1:0] sel_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] beat_cnt, cnt_n;

    logic             beat;
    logic             release_now;
    logic [SEL_W-1:0] search_ptr;
    pick_t            pick;

    // First set request searching cyclically from p upward.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] r,
                                      input logic [SEL_W-1:0] p);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = p + SEL_W'(i);
            if (!res.found && r[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    Mux8x1_16Bit u_mux (
        .op (sel),
        .a  (in0),
        .b  (in1),
        .c  (in2),
        .d  (in3),
        .e  (in4),
        .f  (in5),
        .g  (in6),
        .h  (in7),
        .y  (out_data)
    );

    assign busy      = (state == ARB_GRANT);
    assign out_valid = busy && req[sel];
    assign beat      = out_valid && out_ready;

    assign release_now = busy && (!req[sel] || (beat && beat_cnt == LAST_BEAT));

    // On release the search starts just past the departing requester so it
    // is considered last; this makes the handoff zero-bubble.
    assign search_ptr = release_now ? sel + SEL_W'(1) : ptr;
    assign pick       = rr_pick(req, search_ptr);

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = beat_cnt;

        case (state)
            ARB_IDLE: begin
                if (pick.found) begin
                    state_n = ARB_GRANT;
                    grant_n = onehot(pick.idx);
                    sel_n   = pick.idx;
                    cnt_n   = '0;
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    ptr_n = sel + SEL_W'(1);
                    cnt_n = '0;
                    if (pick.found) begin
                        grant_n = onehot(pick.idx);
                        sel_n   = pick.idx;
                    end else begin
                        state_n = ARB_IDLE;
                        grant_n = '0;
                    end
                end else if (beat) begin
                    cnt_n = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ARB_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            beat_cnt <= cnt_n;
        end
    end

endmodule
